// File: rtl/ahb_lite_pkg.sv
// AHB-Lite encodings, slave FSM states and the byte-lane decode shared by the SRAM slave.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_STALL,
    ST_ERR1,
    ST_ERR2
  } ahb_state_e;

  // Little-endian lane mask; misaligned offsets fall to the size-aligned lanes.
  function automatic logic [3:0] ahb_byte_en(input logic [2:0] size, input logic [1:0] ofs);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << ofs;
      HSIZE_HALF: be = ofs[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sram_sp_be.sv
// Single-port AW x 32 SRAM with per-byte write enables and a registered 1-cycle read.
module sram_sp_be #(
  parameter int unsigned AW = 17
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/iahb_sram_slave.sv
// Zero-wait AHB-Lite SRAM slave with a posted one-entry write buffer and read forwarding.
// Define IAHB_SRAM_ERR_RESP_EN to reject out-of-range, oversized and misaligned transfers with ERROR.
module iahb_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 524288,
  parameter int unsigned AW        = $clog2(MEM_BYTES) - 2
) (
  input  logic        sys_clk,
  input  logic        sys_resetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic [1:0]  hresp
);

  logic [31:0]   off;
  logic [AW-1:0] a_waddr;
  logic [3:0]    a_be;
  logic          a_err;
  logic          a_req, read_req, conflict, accept, read_go, wr_done, drain;
  logic          rd_phase, fwd_hit;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_rdata;
  logic          unused_ok;

  ahb_state_e    state_q, state_d;
  logic          dp_write_q, dp_write_d;
  logic [AW-1:0] dp_addr_q, dp_addr_d;
  logic [3:0]    dp_be_q, dp_be_d;
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [3:0]    wb_be_q, wb_be_d;

  assign off     = haddr - BASE_ADDR;
  assign a_waddr = off[AW+1:2];
  assign a_be    = ahb_byte_en(hsize, off[1:0]);

`ifdef IAHB_SRAM_ERR_RESP_EN
  assign a_err = (off >= 32'(MEM_BYTES)) || (hsize > HSIZE_WORD) ||
                 ((hsize == HSIZE_HALF) && haddr[0]) ||
                 ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
`else
  assign a_err = 1'b0;
`endif

  assign unused_ok = ^{hburst, hprot, off};

  // A read address phase needs the port while a write wants into an occupied wbuf: stall once.
  assign a_req    = hsel & (htrans != HTRANS_IDLE) & (htrans != HTRANS_BUSY);
  assign read_req = a_req & ~hwrite & ~a_err;
  assign conflict = (state_q == ST_DATA) & dp_write_q & wb_valid_q & read_req;
  assign hready   = ~conflict & (state_q != ST_ERR1);
  assign accept   = a_req & hready;
  assign read_go  = accept & ~hwrite & ~a_err;
  assign wr_done  = ((state_q == ST_DATA) | (state_q == ST_STALL)) & dp_write_q & hready;
  assign drain    = wb_valid_q & ~read_go;

  assign hresp = ((state_q == ST_ERR1) | (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q    <= ST_IDLE;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      dp_be_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_be_q    <= '0;
    end else begin
      state_q    <= state_d;
      dp_write_q <= dp_write_d;
      dp_addr_q  <= dp_addr_d;
      dp_be_q    <= dp_be_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      wb_be_q    <= wb_be_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dp_write_d = dp_write_q;
    dp_addr_d  = dp_addr_q;
    dp_be_d    = dp_be_q;
    wb_valid_d = wb_valid_q & ~drain;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wb_be_d    = wb_be_q;

    if (wr_done) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = dp_addr_q;
      wb_data_d  = hwdata;
      wb_be_d    = dp_be_q;
    end

    if (accept && !a_err) begin
      dp_write_d = hwrite;
      dp_addr_d  = a_waddr;
      dp_be_d    = a_be;
    end

    case (state_q)
      ST_IDLE, ST_DATA, ST_STALL, ST_ERR2: begin
        if (conflict)    state_d = ST_STALL;
        else if (accept) state_d = a_err ? ST_ERR1 : ST_DATA;
        else             state_d = ST_IDLE;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data phase: wbuf bytes override stale SRAM bytes of the same word.
  assign rd_phase = (state_q == ST_DATA) & ~dp_write_q;
  assign fwd_hit  = rd_phase & wb_valid_q & (wb_addr_q == dp_addr_q);

  always_comb begin
    hrdata = '0;
    if (rd_phase) begin
      for (int i = 0; i < 4; i++) begin
        hrdata[8*i +: 8] = (fwd_hit && wb_be_q[i]) ? wb_data_q[8*i +: 8] : sram_rdata[8*i +: 8];
      end
    end
  end

  assign sram_en   = read_go | drain;
  assign sram_we   = ~read_go;
  assign sram_addr = read_go ? a_waddr : wb_addr_q;

  sram_sp_be #(
    .AW (AW)
  ) u_sram (
    .clk_i   (sys_clk),
    .en_i    (sram_en),
    .we_i    (sram_we),
    .addr_i  (sram_addr),
    .be_i    (wb_be_q),
    .wdata_i (wb_data_q),
    .rdata_o (sram_rdata)
  );

endmodule

// File: tb/tb_iahb_sram_slave.sv
// Directed bench for iahb_sram_slave: forwarding, conflict stall, reset loss, alias or error response.
`timescale 1ns/1ps
module tb_iahb_sram_slave;
  import ahb_lite_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_resetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;

  int          n_cmp = 0;
  int          n_err = 0;
  int          low_cnt = 0;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic [1:0]  s_resp;

  always #5 sys_clk = ~sys_clk;

  iahb_sram_slave dut (
    .sys_clk    (sys_clk),
    .sys_resetn (sys_resetn),
    .hsel       (hsel),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hburst     (hburst),
    .hprot      (hprot),
    .hwdata     (hwdata),
    .hrdata     (hrdata),
    .hready     (hready),
    .hresp      (hresp)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus cycle: address-phase fields plus the data-phase hwdata; outputs sampled mid-cycle.
  task automatic step(input logic [1:0] tr, input logic wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata);
    hsel   = 1'b1;
    htrans = tr;
    hwrite = wr;
    haddr  = addr;
    hsize  = size;
    hwdata = wdata;
    @(negedge sys_clk);
    s_rdata = hrdata;
    s_ready = hready;
    s_resp  = hresp;
    if (!s_ready) low_cnt++;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sys_resetn = 1'b0;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; haddr = '0;
    hsize = HSIZE_WORD; hburst = '0; hprot = '0; hwdata = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    check_eq("rst_hready", 32'(hready), 32'd1);
    check_eq("rst_hresp",  32'(hresp),  32'd0);
    check_eq("rst_hrdata", hrdata,      32'd0);
    @(negedge sys_clk);
    sys_resetn = 1'b1;
    @(posedge sys_clk);
    #1;

    // Write then immediate read of the same word: forwarded, no wait state.
    low_cnt = 0;
    step(HTRANS_NONSEQ, 1'b1, 32'h100, HSIZE_WORD, 32'h0);
    step(HTRANS_NONSEQ, 1'b0, 32'h100, HSIZE_WORD, 32'hDEAD_BEEF);
    check_eq("t1_rdata_wphase", s_rdata, 32'h0);
    step(HTRANS_BUSY, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
    check_eq("t1_rdata", s_rdata, 32'hDEAD_BEEF);
    check_eq("t1_no_wait", 32'(low_cnt), 32'd0);

    // Word then byte lane 3, then read: one conflict stall, merged result.
    step(HTRANS_NONSEQ, 1'b1, 32'h100, HSIZE_WORD, 32'h0);
    step(HTRANS_NONSEQ, 1'b1, 32'h103, HSIZE_BYTE, 32'h1122_3344);
    step(HTRANS_NONSEQ, 1'b0, 32'h100, HSIZE_WORD, 32'hA500_0000);
    check_eq("t2_stall", 32'(s_ready), 32'd0);
    step(HTRANS_NONSEQ, 1'b0, 32'h100, HSIZE_WORD, 32'hA500_0000);
    check_eq("t2_release", 32'(s_ready), 32'd1);
    step(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
    check_eq("t2_rdata", s_rdata, 32'hA522_3344);

    // Preload 0x8 = 7, then W0=1, W4=2, R8 with exactly one wait state.
    step(HTRANS_NONSEQ, 1'b1, 32'h8, HSIZE_WORD, 32'h0);
    step(HTRANS_IDLE,   1'b0, 32'h0, HSIZE_WORD, 32'h7);
    step(HTRANS_IDLE,   1'b0, 32'h0, HSIZE_WORD, 32'h0);
    low_cnt = 0;
    step(HTRANS_NONSEQ, 1'b1, 32'h0, HSIZE_WORD, 32'h0);
    step(HTRANS_SEQ,    1'b1, 32'h4, HSIZE_WORD, 32'h1);
    step(HTRANS_NONSEQ, 1'b0, 32'h8, HSIZE_WORD, 32'h2);
    step(HTRANS_NONSEQ, 1'b0, 32'h8, HSIZE_WORD, 32'h2);
    step(HTRANS_NONSEQ, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
    check_eq("t3_r8", s_rdata, 32'h7);
    step(HTRANS_SEQ,    1'b0, 32'h4, HSIZE_WORD, 32'h0);
    check_eq("t3_r0", s_rdata, 32'h1);
    step(HTRANS_IDLE,   1'b0, 32'h0, HSIZE_WORD, 32'h0);
    check_eq("t3_r4", s_rdata, 32'h2);
    check_eq("t3_wait_cnt", 32'(low_cnt), 32'd1);

    // Reset while a posted write sits in wbuf and a read is in its data phase.
    step(HTRANS_NONSEQ, 1'b1, 32'h200, HSIZE_WORD, 32'h0);
    step(HTRANS_IDLE,   1'b0, 32'h0,   HSIZE_WORD, 32'hAAAA_5555);
    step(HTRANS_IDLE,   1'b0, 32'h0,   HSIZE_WORD, 32'h0);
    step(HTRANS_NONSEQ, 1'b1, 32'h200, HSIZE_WORD, 32'h0);
    step(HTRANS_NONSEQ, 1'b0, 32'h300, HSIZE_WORD, 32'h1234_5678);
    sys_resetn = 1'b0;
    htrans = HTRANS_IDLE;
    hsel   = 1'b0;
    #2;
    check_eq("rst2_hready", 32'(hready), 32'd1);
    check_eq("rst2_hresp",  32'(hresp),  32'd0);
    check_eq("rst2_hrdata", hrdata,      32'd0);
    @(negedge sys_clk);
    check_eq("rst2_hrdata_hold", hrdata, 32'd0);
    sys_resetn = 1'b1;
    @(posedge sys_clk);
    #1;
    step(HTRANS_NONSEQ, 1'b0, 32'h200, HSIZE_WORD, 32'h0);
    step(HTRANS_IDLE,   1'b0, 32'h0,   HSIZE_WORD, 32'h0);
    check_eq("rst2_lost_write", s_rdata, 32'hAAAA_5555);

`ifdef IAHB_SRAM_ERR_RESP_EN
    // Out-of-range read: two-cycle ERROR response.
    step(HTRANS_NONSEQ, 1'b0, 32'h0008_0000, HSIZE_WORD, 32'h0);
    check_eq("e_addr_ready", 32'(s_ready), 32'd1);
    step(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
    check_eq("e1_ready", 32'(s_ready), 32'd0);
    check_eq("e1_resp",  32'(s_resp),  32'(HRESP_ERROR));
    step(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
    check_eq("e2_ready", 32'(s_ready), 32'd1);
    check_eq("e2_resp",  32'(s_resp),  32'(HRESP_ERROR));
    // Misaligned halfword write is rejected and memory is untouched.
    step(HTRANS_NONSEQ, 1'b1, 32'h101, HSIZE_HALF, 32'h0);
    step(HTRANS_IDLE,   1'b0, 32'h0,   HSIZE_WORD, 32'h0000_CAFE);
    check_eq("m1_ready", 32'(s_ready), 32'd0);
    check_eq("m1_resp",  32'(s_resp),  32'(HRESP_ERROR));
    step(HTRANS_IDLE,   1'b0, 32'h0,   HSIZE_WORD, 32'h0);
    check_eq("m2_ready", 32'(s_ready), 32'd1);
    check_eq("m2_resp",  32'(s_resp),  32'(HRESP_ERROR));
    step(HTRANS_NONSEQ, 1'b0, 32'h100, HSIZE_WORD, 32'h0);
    step(HTRANS_IDLE,   1'b0, 32'h0,   HSIZE_WORD, 32'h0);
    check_eq("m_mem_unchanged", s_rdata, 32'hA522_3344);
    check_eq("m_resp_okay", 32'(s_resp), 32'(HRESP_OKAY));
`else
    // Upper address bits alias onto the region.
    step(HTRANS_NONSEQ, 1'b0, 32'h0008_0100, HSIZE_WORD, 32'h0);
    step(HTRANS_IDLE,   1'b0, 32'h0,         HSIZE_WORD, 32'h0);
    check_eq("alias_rdata", s_rdata, 32'hA522_3344);
    check_eq("alias_resp",  32'(s_resp), 32'(HRESP_OKAY));
    // Misaligned halfword falls to lanes 1:0.
    step(HTRANS_NONSEQ, 1'b1, 32'h101, HSIZE_HALF, 32'h0);
    step(HTRANS_NONSEQ, 1'b0, 32'h100, HSIZE_WORD, 32'h0000_CAFE);
    step(HTRANS_IDLE,   1'b0, 32'h0,   HSIZE_WORD, 32'h0);
    check_eq("half_misalign", s_rdata, 32'hA522_CAFE);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iahb_sram_slave.md
# iahb_sram_slave

Zero-wait-state AHB-Lite slave fronting a single-port byte-enabled SRAM. Sits directly downstream of the E902 instruction AHB-Lite port and serves the instruction/boot memory region. Writes are posted through a one-entry write buffer, so back-to-back reads and writes normally complete without wait states. A wait state is inserted only on a genuine port conflict.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the region.
- MEM_BYTES, 524288, memory size in bytes; power of two, at least 4.
- AW, log2(MEM_BYTES)-2 = 17, SRAM word-address width.

Ports:
- sys_clk  in  1  single clock.
- sys_resetn  in  1  asynchronous, active-low reset.
- hsel  in  1  slave select; tie to 1 when this is the sole slave.
- haddr  in  32  address-phase address.
- htrans  in  2  transfer type; only NONSEQ/SEQ (htrans[1]=1) start a transfer.
- hwrite  in  1  1 = write.
- hsize  in  3  0 = byte, 1 = halfword, 2 = word.
- hburst, hprot  in  3, 4  accepted and ignored.
- hwdata  in  32  write data, valid in the data phase.
- hrdata  out  32  read data.
- hready  out  1  transfer done. This is the sole slave, so hready doubles as the bus HREADY input.
- hresp  out  2  0 = OKAY, 1 = ERROR.

## Operation
- Address phase is accepted when hsel & hready & htrans[1]. The accept registers valid, write, word address, byte offset and byte-enable mask.
- Byte enables:
  - size 0: 1 << addr[1:0].
  - size 1: 4'b0011 when addr[1]=0, else 4'b1100.
  - size 2: 4'b1111.
  - Little-endian lanes; hwdata is used unshifted.
- Reads: the SRAM read is issued in the address-phase cycle. Data is returned in the next cycle.
- Writes: in the data phase, {word addr, hwdata, be} is captured into the write buffer (wbuf) at the clock edge.
- wbuf drain: wbuf is written to the SRAM in any cycle where the port is not claimed by an accepted read address phase.
- Forwarding: in a read data phase, if wbuf is valid and its address equals the read word address, hrdata takes wbuf bytes where be=1 and SRAM bytes elsewhere.
- hrdata is 0 outside read data phases.
- Conflict: a write data phase arrives while wbuf is still valid and the current address phase is a read. Required behaviour:
  - enter STALL and drive hready=0 for one cycle;
  - drain the old wbuf in that cycle and do not issue the read;
  - on the next cycle, hready=1, the new write is captured and the read is issued.
- FSM states: IDLE, DATA, STALL, ERR1, ERR2.
  - IDLE -> DATA on accept.
  - DATA -> DATA on accept, -> IDLE otherwise.
  - DATA -> STALL on conflict; STALL -> DATA.
  - ERR transitions: see Configuration.
- Reset: hready=1, hresp=OKAY, hrdata=0, state=IDLE, wbuf invalid.
  - A write posted in wbuf but not yet drained is lost on reset. This is accepted behaviour.

## Timing
- Read latency: one cycle (zero wait states), including reads forwarded from wbuf.
- Write: zero wait states. The SRAM update lags by at least one cycle, but reads never see stale data.
- Maximum one wait state per conflict. No combinational path from hwdata to hready.
- The SRAM macro has a registered address and a 1-cycle read; its output is used combinationally for the merge.

## Configuration
- Macro: IAHB_SRAM_ERR_RESP_EN.
- Defined: an address phase is rejected if any of the following hold:
  - haddr lies outside [BASE_ADDR, BASE_ADDR+MEM_BYTES);
  - hsize > 2;
  - haddr is misaligned for hsize.
- Rejected transfers get the two-cycle ERROR sequence:
  - ERR1: hready=0, hresp=ERROR.
  - ERR2: hready=1, hresp=ERROR.
  - No SRAM access is made and the write is discarded.
  - If wbuf is still valid, it drains during ERR1.
- Undefined: no ERR states and hresp is always OKAY.
  - Upper address bits are ignored, so addresses alias modulo MEM_BYTES.
  - Misaligned offsets are forced down to hsize alignment.
  - hsize > 2 is treated as a word access.

## Structure
- Shared package ahb_lite_pkg holds the HTRANS_IDLE/BUSY/NONSEQ/SEQ, HSIZE_BYTE/HALF/WORD and HRESP_OKAY/ERROR constants, plus the FSM state enum.
- Sub-module sram_sp_be: single-port AW x 32 SRAM with 4 byte-write enables, inferred as BSRAM.
- Top level holds the FSM, address/data-phase registers, wbuf, forwarding merge and error decode.

## Test plan
- Reset asserted mid-transfer: hready=1, hresp=0, hrdata=0 while reset is low; a pending wbuf write is absent on readback.
- Write word 0x100 = 0xDEADBEEF, then read 0x100 back-to-back: hrdata=0xDEADBEEF, hready never low.
- Word 0x11223344 at 0x100, byte write 0xA5 at 0x103, immediate read 0x100: hrdata=0xA5223344.
- Sequence W 0x0 = 1, W 0x4 = 2, R 0x8 (0x8 preloaded with 7): exactly one hready=0 cycle in the second write's data phase; R returns 7; later reads give 1 and 2.
- With IAHB_SRAM_ERR_RESP_EN, read 0x0008_0000: hready 0/ERROR then 1/ERROR. Halfword write at 0x101: the same sequence, and memory is unchanged.
- Without the macro, read 0x0008_0100 returns the word stored at 0x100 with hresp=OKAY.
